// File: rtl/fb_access_arbiter.sv
// Single-port frame buffer arbiter: vsync-framed camera writes vs. reader requests, one access per clock.
// Optional feature macro: FB_ABORT_CNT_EN adds abort_cnt_o (saturating count of aborted frames).
module fb_access_arbiter #(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 12,
    parameter int PIXELS   = 76800,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync_i,
    input  logic              wr_req_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ack_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_gnt_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef FB_ABORT_CNT_EN
    output logic [7:0]        abort_cnt_o,
`endif
    output logic              frame_done_o
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
    localparam logic [WC_W-1:0]   WAIT_MAX  = WC_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_vs_q;
    logic              r_armed;
    logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [WC_W-1:0]   r_wait_cnt, w_wait_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_rd_p1;
    logic              r_rd_valid;
    logic              r_frame_done;
    logic              w_edge;
    logic              w_wr_elig;
    logic              w_wr_gnt;
    logic              w_rd_gnt;
    logic              w_last;

    // r_armed masks the first cycle after reset so a vsync already high is not taken as an edge
    assign w_edge    = vsync_i & ~r_vs_q & r_armed;
    assign w_wr_elig = wr_req_i & (r_state == ST_ACTIVE) & ~w_edge;
    assign w_wr_gnt  = w_wr_elig & (r_wait_cnt < WAIT_MAX);
    assign w_rd_gnt  = ~w_wr_gnt & rd_req_i;
    assign w_last    = (r_wr_ptr == LAST_ADDR);

    assign wr_ack_o     = w_wr_gnt;
    assign rd_gnt_o     = w_rd_gnt;
    assign rd_valid_o   = r_rd_valid;
    assign rd_data_o    = mem_rdata_i;
    assign mem_addr_o   = r_mem_addr;
    assign mem_we_o     = r_mem_we;
    assign mem_wdata_o  = r_mem_wdata;
    assign frame_done_o = r_frame_done;

    // Next-state, write pointer and read starvation counter
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_wait_nxt   = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) w_state_nxt = ST_ACTIVE;
                else        w_state_nxt = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (w_edge)                 w_state_nxt = ST_ACTIVE;
                else if (w_wr_gnt && w_last) w_state_nxt = ST_DONE;
                else                        w_state_nxt = ST_ACTIVE;
            end
            ST_DONE: begin
                if (w_edge) w_state_nxt = ST_ACTIVE;
                else        w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_edge)                   w_wr_ptr_nxt = {ADDR_W{1'b0}};
        else if (w_wr_gnt && !w_last) w_wr_ptr_nxt = r_wr_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
        else                          w_wr_ptr_nxt = r_wr_ptr;
        if (rd_req_i && !w_rd_gnt) begin
            if (r_wait_cnt < WAIT_MAX) w_wait_nxt = r_wait_cnt + {{(WC_W-1){1'b0}}, 1'b1};
            else                       w_wait_nxt = r_wait_cnt;
        end else begin
            w_wait_nxt = {WC_W{1'b0}};
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_vs_q     <= 1'b0;
            r_armed    <= 1'b0;
            r_wr_ptr   <= {ADDR_W{1'b0}};
            r_wait_cnt <= {WC_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_vs_q     <= vsync_i;
            r_armed    <= 1'b1;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // Memory port and read-return pipeline; address/data hold when nothing is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr   <= {ADDR_W{1'b0}};
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= {DATA_W{1'b0}};
            r_rd_p1      <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_wr_gnt) begin
                r_mem_addr  <= r_wr_ptr;
                r_mem_wdata <= wr_data_i;
                r_mem_we    <= 1'b1;
            end else if (w_rd_gnt) begin
                r_mem_addr  <= rd_addr_i;
                r_mem_we    <= 1'b0;
            end else begin
                r_mem_we    <= 1'b0;
            end
            r_rd_p1      <= w_rd_gnt;
            r_rd_valid   <= r_rd_p1;
            r_frame_done <= w_wr_gnt & w_last;
        end
    end

`ifdef FB_ABORT_CNT_EN
    logic [7:0] r_abort_cnt;
    assign abort_cnt_o = r_abort_cnt;

    // Counts frames cut short by a new vsync while writing was under way
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abort_cnt <= 8'd0;
        end else if (w_edge && (r_state == ST_ACTIVE) && (r_wr_ptr != {ADDR_W{1'b0}})
                     && (r_abort_cnt != 8'hFF)) begin
            r_abort_cnt <= r_abort_cnt + 8'd1;
        end else begin
            r_abort_cnt <= r_abort_cnt;
        end
    end
`endif

endmodule
